// File: rtl/seq_mult_ctrl_pkg.sv
// Shared definitions for the sequential shift-add multiplier controller:
// state encodings, default operand width and the iteration counter width.
package seq_mult_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } mult_state_e;

   localparam int MULT_WIDTH_DEF = 16;

   // Bits needed to count 0 .. w-1 without wrapping.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/mult_addsub.sv
// Ripple-carry add/subtract over W bits, one full-adder cell per bit.
// sub=1 inverts y and forces carry-in, giving x - y.
module mult_addsub #(
   parameter int W = 17
) (
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         sub,
   output logic [W-1:0] sum
);

   logic [W-1:0] y_eff;
   logic [W-1:0] c;

   assign y_eff = y ^ {W{sub}};
   assign c[0]  = sub;

   for (genvar i = 0; i < W; i++) begin : g_fa
      assign sum[i] = x[i] ^ y_eff[i] ^ c[i];
      if (i < W - 1) begin : g_carry
         assign c[i+1] = (x[i] & y_eff[i]) | (x[i] & c[i]) | (y_eff[i] & c[i]);
      end
   end

endmodule

// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add multiplier controller: one shared add/subtract over WIDTH cycles.
// Define MULT_SIGNED_EN to add the sgn_i port and two's-complement support.
//
// state | meaning
// IDLE  | ready, waiting for start_i; captures operands on start
// RUN   | one shift-add iteration per cycle, WIDTH cycles
// DONE  | product_o freshly valid, done_o pulse, back to IDLE
module seq_mult_ctrl
   import seq_mult_ctrl_pkg::*;
#(
   parameter int WIDTH = MULT_WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
`ifdef MULT_SIGNED_EN
   input  logic               sgn_i,
`endif
   output logic               ready_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] product_o
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   mult_state_e        state_q, state_d;
   logic [WIDTH-1:0]   m_q, m_d;
   logic [2*WIDTH-1:0] p_q, p_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] product_q, product_d;

   logic               sgn_mode;
   logic               last_iter;
   logic [WIDTH-1:0]   p_hi;
   logic [WIDTH:0]     add_x, add_y, add_sum;
   logic               add_sub;

`ifdef MULT_SIGNED_EN
   logic sgn_q, sgn_d;
   assign sgn_mode = sgn_q;
`else
   assign sgn_mode = 1'b0;
`endif

   assign last_iter = (cnt_q == CNT_LAST);
   assign p_hi      = p_q[2*WIDTH-1:WIDTH];
   assign add_x     = {sgn_mode & p_hi[WIDTH-1], p_hi};
   assign add_y     = p_q[0] ? {sgn_mode & m_q[WIDTH-1], m_q} : '0;
`ifdef MULT_SIGNED_EN
   // Signed multiplier's MSB carries weight -2^(W-1): subtract on the last step.
   assign add_sub   = sgn_mode & last_iter & p_q[0];
`else
   assign add_sub   = 1'b0;
`endif

   mult_addsub #(.W(WIDTH + 1)) u_addsub (
      .x   (add_x),
      .y   (add_y),
      .sub (add_sub),
      .sum (add_sum)
   );

   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      p_d       = p_q;
      cnt_d     = cnt_q;
      product_d = product_q;
`ifdef MULT_SIGNED_EN
      sgn_d     = sgn_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               m_d     = a_i;
               p_d     = {{WIDTH{1'b0}}, b_i};
               cnt_d   = '0;
`ifdef MULT_SIGNED_EN
               sgn_d   = sgn_i;
`endif
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            p_d = {add_sum, p_q[WIDTH-1:1]};
            if (last_iter) begin
               product_d = p_d;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         m_q       <= '0;
         p_q       <= '0;
         cnt_q     <= '0;
         product_q <= '0;
`ifdef MULT_SIGNED_EN
         sgn_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         p_q       <= p_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
`ifdef MULT_SIGNED_EN
         sgn_q     <= sgn_d;
`endif
      end
   end

   assign ready_o   = (state_q == ST_IDLE);
   assign busy_o    = (state_q == ST_RUN) || (state_q == ST_DONE);
   assign done_o    = (state_q == ST_DONE);
   assign product_o = product_q;

endmodule
